// File: rtl/id_ex_stage_reg.sv
// id_ex_stage_reg: ID/EX pipeline register with bubble/flush insertion, statistics
// counters and a consecutive-stall watchdog.
module id_ex_stage_reg #(
    parameter int MAX_STALL = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        nop_lock_id,
    input  logic        flush_id,
    input  logic        halt,
    input  logic        RegWrite_id,
    input  logic        MemRead_id,
    input  logic        MemWrite_id,
    input  logic        MemtoReg_id,
    input  logic        ALUSrc_id,
    input  logic [3:0]  ALUOp_id,
    input  logic [31:0] regfile_read_data1_id,
    input  logic [31:0] regfile_read_data2_id,
    input  logic [31:0] imm_id,
    input  logic [31:0] pc_plus4_id,
    input  logic [4:0]  regfile_write_num_id,
    output logic        RegWrite_id_ex,
    output logic        MemRead_id_ex,
    output logic        MemWrite_id_ex,
    output logic        MemtoReg_id_ex,
    output logic        ALUSrc_id_ex,
    output logic        valid_id_ex,
    output logic [3:0]  ALUOp_id_ex,
    output logic [31:0] regfile_read_data1_id_ex,
    output logic [31:0] regfile_read_data2_id_ex,
    output logic [31:0] imm_id_ex,
    output logic [31:0] pc_plus4_id_ex,
    output logic [4:0]  regfile_write_num_id_ex,
    output logic [31:0] bubble_count,
    output logic [31:0] flush_count,
    output logic        stall_err
);
    localparam logic RUN = 1'b0;
    localparam logic STALL = 1'b1;
    localparam int CW = $clog2(MAX_STALL + 2);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_STALL + 1);

    logic [141:0]   pipe_d, pipe_q;
    logic           valid_d, valid_q;
    logic [31:0]    bubble_cnt_d, bubble_cnt_q;
    logic [31:0]    flush_cnt_d, flush_cnt_q;
    logic           state_d, state_q;
    logic [CW-1:0]  run_cnt_d, run_cnt_q;
    logic           err_d, err_q;
    logic           bubble;

    assign bubble = flush_id | nop_lock_id;

    always_comb begin
        pipe_d       = pipe_q;
        valid_d      = valid_q;
        bubble_cnt_d = bubble_cnt_q;
        flush_cnt_d  = flush_cnt_q;
        state_d      = state_q;
        run_cnt_d    = run_cnt_q;
        if (!halt) begin
            pipe_d  = bubble ? '0 : {RegWrite_id, MemRead_id, MemWrite_id, MemtoReg_id, ALUSrc_id,
                                     ALUOp_id, regfile_read_data1_id, regfile_read_data2_id,
                                     imm_id, pc_plus4_id, regfile_write_num_id};
            valid_d = !bubble;
            // a flush absorbs a simultaneous hazard, so only one counter moves
            flush_cnt_d  = (flush_id && flush_cnt_q != '1) ? flush_cnt_q + 32'd1 : flush_cnt_q;
            bubble_cnt_d = (!flush_id && nop_lock_id && bubble_cnt_q != '1) ? bubble_cnt_q + 32'd1 : bubble_cnt_q;
            if (state_q == RUN) begin
                if (nop_lock_id && !flush_id) begin
                    state_d   = STALL;
                    run_cnt_d = CW'(1);
                end
            end else if (flush_id || !nop_lock_id) begin
                state_d   = RUN;
                run_cnt_d = '0;
            end else begin
                run_cnt_d = (run_cnt_q == CNT_MAX) ? run_cnt_q : run_cnt_q + CW'(1);
            end
        end
        err_d = err_q | (run_cnt_d == CNT_MAX);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_q       <= '0;
            valid_q      <= 1'b0;
            bubble_cnt_q <= '0;
            flush_cnt_q  <= '0;
            state_q      <= RUN;
            run_cnt_q    <= '0;
            err_q        <= 1'b0;
        end else begin
            pipe_q       <= pipe_d;
            valid_q      <= valid_d;
            bubble_cnt_q <= bubble_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
            state_q      <= state_d;
            run_cnt_q    <= run_cnt_d;
            err_q        <= err_d;
        end
    end

    assign {RegWrite_id_ex, MemRead_id_ex, MemWrite_id_ex, MemtoReg_id_ex, ALUSrc_id_ex,
            ALUOp_id_ex, regfile_read_data1_id_ex, regfile_read_data2_id_ex,
            imm_id_ex, pc_plus4_id_ex, regfile_write_num_id_ex} = pipe_q;
    assign valid_id_ex  = valid_q;
    assign bubble_count = bubble_cnt_q;
    assign flush_count  = flush_cnt_q;
    assign stall_err    = err_q;
endmodule

// File: tb/tb_id_ex_stage_reg.sv
// tb_id_ex_stage_reg: directed-vector bench for id_ex_stage_reg with hand-computed expectations.
module tb_id_ex_stage_reg;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        nop_lock_id = 1'b0, flush_id = 1'b0, halt = 1'b0;
    logic        RegWrite_id = 1'b0, MemRead_id = 1'b0, MemWrite_id = 1'b0, MemtoReg_id = 1'b0, ALUSrc_id = 1'b0;
    logic [3:0]  ALUOp_id = '0;
    logic [31:0] regfile_read_data1_id = '0, regfile_read_data2_id = '0, imm_id = '0, pc_plus4_id = '0;
    logic [4:0]  regfile_write_num_id = '0;
    logic        RegWrite_id_ex, MemRead_id_ex, MemWrite_id_ex, MemtoReg_id_ex, ALUSrc_id_ex, valid_id_ex;
    logic [3:0]  ALUOp_id_ex;
    logic [31:0] regfile_read_data1_id_ex, regfile_read_data2_id_ex, imm_id_ex, pc_plus4_id_ex;
    logic [4:0]  regfile_write_num_id_ex;
    logic [31:0] bubble_count, flush_count;
    logic        stall_err;
    int          n_cmp = 0, n_err = 0;

    id_ex_stage_reg #(.MAX_STALL(2)) dut (
        .clk(clk), .rst_n(rst_n), .nop_lock_id(nop_lock_id), .flush_id(flush_id), .halt(halt),
        .RegWrite_id(RegWrite_id), .MemRead_id(MemRead_id), .MemWrite_id(MemWrite_id),
        .MemtoReg_id(MemtoReg_id), .ALUSrc_id(ALUSrc_id), .ALUOp_id(ALUOp_id),
        .regfile_read_data1_id(regfile_read_data1_id), .regfile_read_data2_id(regfile_read_data2_id),
        .imm_id(imm_id), .pc_plus4_id(pc_plus4_id), .regfile_write_num_id(regfile_write_num_id),
        .RegWrite_id_ex(RegWrite_id_ex), .MemRead_id_ex(MemRead_id_ex), .MemWrite_id_ex(MemWrite_id_ex),
        .MemtoReg_id_ex(MemtoReg_id_ex), .ALUSrc_id_ex(ALUSrc_id_ex), .valid_id_ex(valid_id_ex),
        .ALUOp_id_ex(ALUOp_id_ex), .regfile_read_data1_id_ex(regfile_read_data1_id_ex),
        .regfile_read_data2_id_ex(regfile_read_data2_id_ex), .imm_id_ex(imm_id_ex),
        .pc_plus4_id_ex(pc_plus4_id_ex), .regfile_write_num_id_ex(regfile_write_num_id_ex),
        .bubble_count(bubble_count), .flush_count(flush_count), .stall_err(stall_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1;
        check("rst_valid", 32'(valid_id_ex), 32'd0);
        check("rst_wnum", 32'(regfile_write_num_id_ex), 32'd0);
        check("rst_bub", bubble_count, 32'd0);
        check("rst_err", 32'(stall_err), 32'd0);
        #2 rst_n = 1'b1;
        // normal capture
        RegWrite_id = 1'b1; regfile_write_num_id = 5'd5; regfile_read_data1_id = 32'h1234;
        ALUOp_id = 4'hA; imm_id = 32'hCAFE; pc_plus4_id = 32'h40;
        step();
        check("norm_rw", 32'(RegWrite_id_ex), 32'd1);
        check("norm_wnum", 32'(regfile_write_num_id_ex), 32'd5);
        check("norm_d1", regfile_read_data1_id_ex, 32'h1234);
        check("norm_valid", 32'(valid_id_ex), 32'd1);
        check("norm_aluop", 32'(ALUOp_id_ex), 32'hA);
        check("norm_pc4", pc_plus4_id_ex, 32'h40);
        // load-use bubble
        MemRead_id = 1'b1; nop_lock_id = 1'b1;
        step();
        check("lu_memrd", 32'(MemRead_id_ex), 32'd0);
        check("lu_rw", 32'(RegWrite_id_ex), 32'd0);
        check("lu_valid", 32'(valid_id_ex), 32'd0);
        check("lu_d1", regfile_read_data1_id_ex, 32'd0);
        check("lu_imm", imm_id_ex, 32'd0);
        check("lu_wnum", 32'(regfile_write_num_id_ex), 32'd0);
        check("lu_bub", bubble_count, 32'd1);
        check("lu_fl", flush_count, 32'd0);
        check("lu_err", 32'(stall_err), 32'd0);
        nop_lock_id = 1'b0; MemRead_id = 1'b0;
        step();
        check("resume_valid", 32'(valid_id_ex), 32'd1);
        // flush with simultaneous hazard: flush only, watchdog stays RUN
        flush_id = 1'b1; nop_lock_id = 1'b1;
        step();
        check("fl_valid", 32'(valid_id_ex), 32'd0);
        check("fl_rw", 32'(RegWrite_id_ex), 32'd0);
        check("fl_fl", flush_count, 32'd1);
        check("fl_bub", bubble_count, 32'd1);
        flush_id = 1'b0;
        step();
        step();
        check("fl_run_err", 32'(stall_err), 32'd0);
        check("fl_run_bub", bubble_count, 32'd3);
        nop_lock_id = 1'b0;
        // halt freezes everything
        regfile_write_num_id = 5'd7;
        step();
        check("pre_halt_wnum", 32'(regfile_write_num_id_ex), 32'd7);
        halt = 1'b1; nop_lock_id = 1'b1;
        for (int i = 0; i < 4; i++) begin
            regfile_write_num_id = 5'(i + 10);
            regfile_read_data1_id = 32'(i * 3 + 1);
            flush_id = i[0];
            step();
        end
        check("halt_wnum", 32'(regfile_write_num_id_ex), 32'd7);
        check("halt_valid", 32'(valid_id_ex), 32'd1);
        check("halt_d1", regfile_read_data1_id_ex, 32'h1234);
        check("halt_bub", bubble_count, 32'd3);
        check("halt_fl", flush_count, 32'd1);
        check("halt_err", 32'(stall_err), 32'd0);
        halt = 1'b0; flush_id = 1'b0; nop_lock_id = 1'b0;
        step();
        // watchdog: three consecutive stalls
        nop_lock_id = 1'b1;
        step();
        step();
        check("wd2_err", 32'(stall_err), 32'd0);
        step();
        check("wd3_err", 32'(stall_err), 32'd1);
        check("wd3_bub", bubble_count, 32'd6);
        nop_lock_id = 1'b0;
        step();
        step();
        check("wd_sticky", 32'(stall_err), 32'd1);
        check("wd_valid", 32'(valid_id_ex), 32'd1);
        // saturation
        force dut.bubble_cnt_q = 32'hFFFF_FFFE;
        #1 release dut.bubble_cnt_q;
        nop_lock_id = 1'b1;
        step();
        check("sat1", bubble_count, 32'hFFFF_FFFF);
        step();
        check("sat2", bubble_count, 32'hFFFF_FFFF);
        nop_lock_id = 1'b0;
        step();
        check("pre_rst_valid", 32'(valid_id_ex), 32'd1);
        // asynchronous reset mid-cycle
        #2 rst_n = 1'b0;
        #1;
        check("arst_valid", 32'(valid_id_ex), 32'd0);
        check("arst_wnum", 32'(regfile_write_num_id_ex), 32'd0);
        check("arst_d1", regfile_read_data1_id_ex, 32'd0);
        check("arst_bub", bubble_count, 32'd0);
        check("arst_fl", flush_count, 32'd0);
        check("arst_err", 32'(stall_err), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/id_ex_stage_reg.md
# id_ex_stage_reg

ID/EX pipeline register for the five-stage MIPS core. It sits directly downstream of the load-use hazard detector and consumes its `nop_lock_id` output. When a hazard or branch flush applies, it launches a bubble into EX instead of the decoded instruction. It feeds the `*_id_ex` control fields back to the hazard detector and keeps bubble/flush statistics plus a stall watchdog.

## Interface
Parameters:
- `MAX_STALL`, 2: maximum consecutive cycles `nop_lock_id` may stay high before `stall_err` sets.

Ports:
- `clk`  in  1  rising-edge clock; all state updates on posedge.
- `rst_n`  in  1  asynchronous active-low reset.
- `nop_lock_id`  in  1  load-use stall request from the hazard detector. It changes on negedge, so it is stable at posedge.
- `flush_id`  in  1  branch/jump taken; the ID instruction is discarded.
- `halt`  in  1  syscall halt; freeze all state.
- `RegWrite_id, MemRead_id, MemWrite_id, MemtoReg_id, ALUSrc_id`  in  1 each  decoded control.
- `ALUOp_id`  in  4  ALU operation.
- `regfile_read_data1_id, regfile_read_data2_id, imm_id, pc_plus4_id`  in  32 each  operands.
- `regfile_write_num_id`  in  5  destination register.
- `RegWrite_id_ex, MemRead_id_ex, MemWrite_id_ex, MemtoReg_id_ex, ALUSrc_id_ex, valid_id_ex`  out  1 each  registered control.
- `ALUOp_id_ex`  out  4.
- `regfile_read_data1_id_ex, regfile_read_data2_id_ex, imm_id_ex, pc_plus4_id_ex`  out  32 each.
- `regfile_write_num_id_ex`  out  5.
- `bubble_count, flush_count`  out  32 each  statistics; both saturate at 0xFFFFFFFF.
- `stall_err`  out  1  sticky watchdog flag.

## Operation
Each posedge is resolved in the following strict priority order:
1. `halt`=1: hold every register, counter and watchdog state unchanged.
2. `flush_id`=1: load a bubble. `flush_count`+1 (saturating). This takes precedence over `nop_lock_id`, so a simultaneous hazard is counted as a flush only.
3. `nop_lock_id`=1: load a bubble. `bubble_count`+1 (saturating).
4. Otherwise: load all `*_id` inputs and set `valid_id_ex`=1.

Bubble definition:
- All control outputs are 0, `valid_id_ex`=0, `regfile_write_num_id_ex`=0.
- Data fields (`regfile_read_data1/2_id_ex`, `imm_id_ex`, `pc_plus4_id_ex`) are also cleared to 0, for deterministic waveforms.

Watchdog FSM, states RUN and STALL:
- RUN → STALL when `nop_lock_id`=1 and not halt/flush; the run counter loads 1.
- In STALL:
  - `nop_lock_id`=1: the counter increments, saturating at `MAX_STALL`+1.
  - `nop_lock_id`=0 or `flush_id`=1: return to RUN and clear the counter.
  - Counter reaching `MAX_STALL`+1: set `stall_err`. It stays set until reset.
- `halt` freezes the FSM.

This block does not stall IF/ID itself. The upstream PC and IF/ID enables use `nop_lock_id` directly.

## Timing
- Reset (`rst_n`=0, asynchronous): all outputs 0, `valid_id_ex`=0, counters 0, `stall_err`=0, FSM in RUN. Release is synchronous to the next posedge.
- Latency: the ID fields appear on the `*_id_ex` outputs one cycle after the capturing posedge. `*_id_ex` outputs are registered only, with no combinational input-to-output path.
- Hazard loop: a load in EX (`MemRead_id_ex`=1) causes the detector to raise `nop_lock_id` at the following negedge. At the next posedge this block loads a bubble, so `MemRead_id_ex` drops to 0. The detector then deasserts `nop_lock_id` at the negedge. This gives exactly one bubble per load-use pair.
- Reset asserted mid-stall or mid-halt: everything clears immediately, and the counters do not retain values.
- Counter saturation: at 0xFFFFFFFF further events leave the value unchanged.

## Test plan
- Reset then normal flow: apply `rst_n`=0, then 1, and drive RegWrite_id=1, write_num=5, data1=0x1234 → next cycle RegWrite_id_ex=1, regfile_write_num_id_ex=5, data1_id_ex=0x1234, valid_id_ex=1.
- Load-use: `nop_lock_id` high for one posedge with MemRead_id=1 presented → outputs all 0, valid_id_ex=0, bubble_count=1, flush_count=0, stall_err=0.
- Simultaneous `flush_id`=1 and `nop_lock_id`=1 → bubble, flush_count=1, bubble_count unchanged at 0, FSM stays RUN.
- Halt: load write_num=7, then `halt`=1 for 4 cycles with changing inputs and `nop_lock_id`=1 → outputs hold write_num=7, counters unchanged, stall_err=0.
- Watchdog: `nop_lock_id` held for 3 consecutive posedges with `MAX_STALL`=2 → stall_err=1 after the third, bubble_count=3. Deassert → stall_err remains 1 until `rst_n`=0.
- Saturation and async reset: force bubble_count to 0xFFFFFFFE, apply 2 hazards → 0xFFFFFFFF. Then pulse `rst_n` low between clock edges → outputs and counters 0 immediately, without waiting for a clock edge.
